ext_mem_ldst_engine: RTL and testbench
======================================

Name: ext_mem_ldst_engine

Overview:
- Initiator side of the external-memory load/store port. The memory model answers `O_Ld_Req` / `O_Ld_Addr` one cycle later on `I_Ld_FTk`, and consumes `O_St_Req` / `O_St_Addr` / `O_St_FTk`.
- The engine accepts one strided block command at a time.
- Load commands: issues the read requests, buffers returned words in a small FIFO and forwards them as a token stream into the array.
- Store commands: drains a token stream from the array into strided memory writes, honouring the memory-side nack.

Parameters:
- `DEPTH_FIFO`, 4, load return-buffer depth (power of two, ≥2).
- `WIDTH_LEN`, 16, width of the block word count.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `I_Cmd_V`  in  1  command valid
- `I_Cmd_St`  in  1  0 = load, 1 = store
- `I_Cmd_Base`  in  `WIDTH_EXADDR`  first word address
- `I_Cmd_Len`  in  `WIDTH_LEN`  word count
- `I_Cmd_Stride`  in  `WIDTH_EXADDR`  address increment per word
- `O_Cmd_Rdy`  out  1  engine idle, command accepted
- `O_Done`  out  1  one-cycle pulse when the block completes
- `O_Ld_Req`  out  1  load request to memory
- `O_Ld_Addr`  out  `WIDTH_EXADDR`  load address
- `I_Ld_FTk`  in  `FTk_t`  load return token (v, a, r, c, i, d)
- `O_Ld_BTk`  out  `BTk_t`  back token to memory; always '0
- `O_FTk`  out  `FTk_t`  load stream into array
- `I_BTk`  in  `BTk_t`  array back token (n = nack, t = terminate)
- `I_FTk`  in  `FTk_t`  store stream from array
- `O_BTk`  out  `BTk_t`  back token to array (n used, others 0)
- `O_St_Req`  out  1  store request
- `O_St_Addr`  out  `WIDTH_EXADDR`  store address
- `O_St_FTk`  out  `FTk_t`  store data token
- `I_St_BTk`  in  `BTk_t`  memory store nack (n)

Behaviour:
- Reset:
  - All outputs 0 except `O_BTk.n` = 1.
  - State IDLE, FIFO empty, counters 0, in-flight flag cleared.
  - A reset mid-operation aborts the block with no `O_Done`.
  - A late `I_Ld_FTk.v` arriving after reset is ignored, because the in-flight flag is 0.
- State machine: IDLE → LD_RUN | ST_RUN → DONE → IDLE.
  - IDLE: `O_Cmd_Rdy` = 1.
  - On `I_Cmd_V`, latch base, len and stride; clear the address index k, issue count, forward count and index counter.
  - `Len` = 0 goes straight to DONE with no memory traffic.
  - DONE lasts one cycle with `O_Done` = 1.
- Address: base + k·stride, computed modulo 2^`WIDTH_EXADDR` (wraps silently).
- LD_RUN issue:
  - `O_Ld_Req` = 1 when issued < len and fifo_count + inflight < `DEPTH_FIFO`.
  - `O_Ld_Addr` is valid in the same cycle.
  - Each request sets inflight for one cycle and increments k.
- LD_RUN return: `I_Ld_FTk.v` with inflight = 1 pushes `d` into the FIFO on the next edge. Memory latency is exactly 1 cycle.
- Load output: `O_FTk` is combinational from the FIFO head.
  - v = ~empty.
  - a = 1 on the first word of the block.
  - r = 1 on the last word (forward count = len−1).
  - c = 0.
  - i = index counter.
  - A word pops when v & ~`I_BTk.n`.
  - Index increments per pop and wraps at the width of the i field.
  - `I_BTk.t` clears the index to 0 (takes priority over increment).
- LD_RUN exit: go to DONE when forwarded == len.
- Simultaneous FIFO push and pop keeps the count unchanged. No overflow by construction; an overflow is an assertion failure.
- ST_RUN: one-entry output register.
  - `O_BTk.n` = reg_valid & `I_St_BTk.n`, forced to 1 outside ST_RUN.
  - `I_FTk.v` & ~`O_BTk.n` loads the register with (addr(k), token) and increments k.
  - `O_St_Req` = reg_valid; `O_St_FTk` / `O_St_Addr` come from the register.
  - A write completes when reg_valid & ~`I_St_BTk.n`. The register may reload in the same cycle.
  - Go to DONE when completed == len. `O_BTk.n` = 1 once len words have been accepted.
- `O_Ld_Req` and `O_St_Req` are never both 1. Commands are ignored while `O_Cmd_Rdy` = 0.

Test Plan:
- Load, base 0x0190, stride 1, len 4, memory returns 0xA0..0xA3, `I_BTk` = 0:
  - addresses 0x190..0x193 on consecutive cycles;
  - `O_FTk` carries d = A0..A3, i = 0..3, a on the first word, r on the last;
  - `O_Done` one cycle after the last pop.
- Same load with `I_BTk.n` held for 6 cycles after word 0:
  - at most 4 requests outstanding-plus-buffered;
  - no loss or reorder; output still A0..A3.
- Store, base 0x0290, stride 2, len 3, data 5, 6, 7, with `I_St_BTk.n` high for 2 cycles on the second word:
  - writes 0x290 = 5, 0x292 = 6, 0x294 = 7 exactly once each;
  - `O_BTk.n` high during the stall.
- Load with `Len` = 0: `O_Done` the cycle after acceptance; `O_Ld_Req` never asserted.
- Wrap, base 0xFFFE, stride 1, len 3 (`WIDTH_EXADDR` = 16): addresses 0xFFFE, 0xFFFF, 0x0000.
- Reset asserted one cycle after the second load request, with memory answering the cycle after:
  - all outputs 0 immediately and `O_Cmd_Rdy` = 1 after release;
  - the late return is not forwarded; a fresh command runs correctly.

Source files
------------

// File: rtl/ext_mem_ldst_engine.sv
// Strided block load/store initiator for the external-memory port.
// Loads are buffered in a small return FIFO; stores go through a one-entry output register.
package ext_mem_ldst_pkg;
    localparam int WIDTH_EXADDR = 16;
    localparam int WIDTH_DATA   = 32;
    localparam int WIDTH_IDX    = 8;

    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  r;
        logic                  c;
        logic [WIDTH_IDX-1:0]  i;
        logic [WIDTH_DATA-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
    } BTk_t;
endpackage

module ext_mem_ldst_engine
    import ext_mem_ldst_pkg::*;
#(
    parameter int DEPTH_FIFO = 4,
    parameter int WIDTH_LEN  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Cmd_V,
    input  logic                    I_Cmd_St,
    input  logic [WIDTH_EXADDR-1:0] I_Cmd_Base,
    input  logic [WIDTH_LEN-1:0]    I_Cmd_Len,
    input  logic [WIDTH_EXADDR-1:0] I_Cmd_Stride,
    output logic                    O_Cmd_Rdy,
    output logic                    O_Done,
    output logic                    O_Ld_Req,
    output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
    input  FTk_t                    I_Ld_FTk,
    output BTk_t                    O_Ld_BTk,
    output FTk_t                    O_FTk,
    input  BTk_t                    I_BTk,
    input  FTk_t                    I_FTk,
    output BTk_t                    O_BTk,
    output logic                    O_St_Req,
    output logic [WIDTH_EXADDR-1:0] O_St_Addr,
    output FTk_t                    O_St_FTk,
    input  BTk_t                    I_St_BTk
);
    localparam int PTR_W = $clog2(DEPTH_FIFO);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LD_RUN, S_ST_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [WIDTH_EXADDR-1:0] addr_q, addr_d, stride_q, stride_d;
    logic [WIDTH_LEN-1:0]    len_q, len_d, k_q, k_d, fwd_q, fwd_d, cmp_q, cmp_d;
    logic [WIDTH_IDX-1:0]    idx_q, idx_d;
    logic                    inflight_q, inflight_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH_DATA-1:0]   mem_q [DEPTH_FIFO];
    logic                    reg_v_q, reg_v_d;
    logic [WIDTH_EXADDR-1:0] reg_addr_q, reg_addr_d;
    FTk_t                    reg_tok_q, reg_tok_d;
    logic                    ld_req, push, pop, fifo_empty, st_acc, st_cmp, bp_n;
    logic                    unused_ok;

    assign unused_ok = ^{I_Ld_FTk.a, I_Ld_FTk.r, I_Ld_FTk.c, I_Ld_FTk.i, I_St_BTk.t};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        len_d      = len_q;
        k_d        = k_q;
        fwd_d      = fwd_q;
        cmp_d      = cmp_q;
        idx_d      = idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        reg_addr_d = reg_addr_q;
        reg_tok_d  = reg_tok_q;

        fifo_empty = (cnt_q == '0);
        // Requests are throttled so returned words always find a free FIFO slot.
        ld_req = (state_q == S_LD_RUN) && (k_q < len_q) &&
                 ((cnt_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH_FIFO));
        push   = inflight_q & I_Ld_FTk.v;
        pop    = ~fifo_empty & ~I_BTk.n;
        bp_n   = (state_q != S_ST_RUN) | (reg_v_q & I_St_BTk.n) | (k_q == len_q);
        st_acc = (state_q == S_ST_RUN) & I_FTk.v & ~bp_n;
        st_cmp = (state_q == S_ST_RUN) & reg_v_q & ~I_St_BTk.n;

        inflight_d = ld_req;
        if (ld_req || st_acc) begin
            k_d    = k_q + WIDTH_LEN'(1);
            addr_d = addr_q + stride_q;
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            fwd_d    = fwd_q + WIDTH_LEN'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (I_BTk.t)  idx_d = '0;
        else if (pop) idx_d = idx_q + WIDTH_IDX'(1);

        if (st_acc) begin
            reg_addr_d = addr_q;
            reg_tok_d  = I_FTk;
        end
        reg_v_d = st_acc | (reg_v_q & ~st_cmp);
        if (st_cmp) cmp_d = cmp_q + WIDTH_LEN'(1);

        case (state_q)
            S_IDLE: begin
                if (I_Cmd_V) begin
                    addr_d   = I_Cmd_Base;
                    stride_d = I_Cmd_Stride;
                    len_d    = I_Cmd_Len;
                    k_d      = '0;
                    fwd_d    = '0;
                    cmp_d    = '0;
                    idx_d    = '0;
                    if (I_Cmd_Len == '0) state_d = S_DONE;
                    else if (I_Cmd_St)   state_d = S_ST_RUN;
                    else                 state_d = S_LD_RUN;
                end
            end
            S_LD_RUN: if (fwd_d == len_q) state_d = S_DONE;
            S_ST_RUN: if (cmp_d == len_q) state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            stride_q   <= '0;
            len_q      <= '0;
            k_q        <= '0;
            fwd_q      <= '0;
            cmp_q      <= '0;
            idx_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            reg_v_q    <= 1'b0;
            reg_addr_q <= '0;
            reg_tok_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            len_q      <= len_d;
            k_q        <= k_d;
            fwd_q      <= fwd_d;
            cmp_q      <= cmp_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            reg_v_q    <= reg_v_d;
            reg_addr_q <= reg_addr_d;
            reg_tok_q  <= reg_tok_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= I_Ld_FTk.d;
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && (cnt_q == CNT_W'(DEPTH_FIFO))));

    // Ready is masked during reset so every output reads as idle-zero while held.
    assign O_Cmd_Rdy = (state_q == S_IDLE) & ~reset;
    assign O_Done    = (state_q == S_DONE);
    assign O_Ld_Req  = ld_req;
    assign O_Ld_Addr = ld_req ? addr_q : '0;
    assign O_Ld_BTk  = '0;
    assign O_BTk     = '{n: bp_n, t: 1'b0};
    assign O_St_Req  = reg_v_q;
    assign O_St_Addr = reg_v_q ? reg_addr_q : '0;
    assign O_St_FTk  = reg_v_q ? reg_tok_q : '0;

    always_comb begin
        O_FTk = '0;
        if (!fifo_empty) begin
            O_FTk.v = 1'b1;
            O_FTk.a = (fwd_q == '0);
            O_FTk.r = (fwd_q == len_q - WIDTH_LEN'(1));
            O_FTk.i = idx_q;
            O_FTk.d = mem_q[rd_ptr_q];
        end
    end
endmodule

// File: tb/tb_ext_mem_ldst_engine.sv
// Directed bench for ext_mem_ldst_engine: load, stalled load, store with nack,
// zero length, address wrap and mid-block reset, against a one-cycle memory model.
module tb_ext_mem_ldst_engine;
    import ext_mem_ldst_pkg::*;

    logic                    clock, reset;
    logic                    I_Cmd_V, I_Cmd_St;
    logic [WIDTH_EXADDR-1:0] I_Cmd_Base, I_Cmd_Stride;
    logic [15:0]             I_Cmd_Len;
    logic                    O_Cmd_Rdy, O_Done, O_Ld_Req, O_St_Req;
    logic [WIDTH_EXADDR-1:0] O_Ld_Addr, O_St_Addr;
    FTk_t                    I_Ld_FTk, O_FTk, I_FTk, O_St_FTk;
    BTk_t                    O_Ld_BTk, I_BTk, O_BTk, I_St_BTk;

    ext_mem_ldst_engine #(.DEPTH_FIFO(4), .WIDTH_LEN(16)) dut (
        .clock(clock), .reset(reset),
        .I_Cmd_V(I_Cmd_V), .I_Cmd_St(I_Cmd_St), .I_Cmd_Base(I_Cmd_Base),
        .I_Cmd_Len(I_Cmd_Len), .I_Cmd_Stride(I_Cmd_Stride),
        .O_Cmd_Rdy(O_Cmd_Rdy), .O_Done(O_Done),
        .O_Ld_Req(O_Ld_Req), .O_Ld_Addr(O_Ld_Addr), .I_Ld_FTk(I_Ld_FTk), .O_Ld_BTk(O_Ld_BTk),
        .O_FTk(O_FTk), .I_BTk(I_BTk), .I_FTk(I_FTk), .O_BTk(O_BTk),
        .O_St_Req(O_St_Req), .O_St_Addr(O_St_Addr), .O_St_FTk(O_St_FTk), .I_St_BTk(I_St_BTk)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observation logs
    int                      cyc, issued, popped, done_cnt, done_cyc, last_pop_cyc, acc_cyc;
    int                      max_out, both_req, nack_bp, bp_left, nack_left;
    logic                    bp_after_first, late_inj;
    logic [WIDTH_EXADDR-1:0] nack_addr;
    logic [WIDTH_EXADDR-1:0] ld_addr_log[$];
    int                      ld_cyc_log[$];
    logic [WIDTH_DATA-1:0]   pop_d_log[$];
    logic [WIDTH_IDX-1:0]    pop_i_log[$];
    logic                    pop_a_log[$], pop_r_log[$];
    logic [WIDTH_EXADDR-1:0] st_addr_log[$];
    logic [WIDTH_DATA-1:0]   st_d_log[$];
    logic [WIDTH_DATA-1:0]   st_src[$];
    logic [WIDTH_EXADDR-1:0] exp_addr_q[$];
    logic [WIDTH_DATA-1:0]   exp_q[$];

    task automatic clear_logs();
        issued = 0; popped = 0; done_cnt = 0; done_cyc = -1; last_pop_cyc = -1; acc_cyc = -1;
        max_out = 0; nack_bp = 0; bp_left = 0; nack_left = 0; nack_addr = '0;
        bp_after_first = 1'b0; late_inj = 1'b0;
        ld_addr_log.delete(); ld_cyc_log.delete(); pop_d_log.delete(); pop_i_log.delete();
        pop_a_log.delete(); pop_r_log.delete(); st_addr_log.delete(); st_d_log.delete();
        st_src.delete(); exp_addr_q.delete(); exp_q.delete();
    endtask

    // One clock: observe at negedge, then drive memory/array inputs #1 after posedge.
    task automatic tick();
        logic                    s_req;
        logic [WIDTH_EXADDR-1:0] s_addr;
        @(negedge clock);
        s_req  = O_Ld_Req;
        s_addr = O_Ld_Addr;
        if (O_Ld_Req && O_St_Req) both_req++;
        if (O_Ld_Req) begin
            ld_addr_log.push_back(O_Ld_Addr);
            ld_cyc_log.push_back(cyc);
            issued++;
        end
        if (O_FTk.v && !I_BTk.n) begin
            pop_d_log.push_back(O_FTk.d);
            pop_i_log.push_back(O_FTk.i);
            pop_a_log.push_back(O_FTk.a);
            pop_r_log.push_back(O_FTk.r);
            popped++;
            last_pop_cyc = cyc;
            if (bp_after_first && popped == 1) bp_left = 6;
        end
        if (issued - popped > max_out) max_out = issued - popped;
        if (O_St_Req && !I_St_BTk.n) begin
            st_addr_log.push_back(O_St_Addr);
            st_d_log.push_back(O_St_FTk.d);
        end
        if (I_St_BTk.n && O_BTk.n) nack_bp++;
        if (I_FTk.v && !O_BTk.n && st_src.size() > 0) st_src.delete(0);
        if (O_Done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (O_Cmd_Rdy && I_Cmd_V) acc_cyc = cyc;
        @(posedge clock);
        #1;
        cyc++;
        I_Ld_FTk = '0;
        if (s_req) begin
            I_Ld_FTk.v = 1'b1;
            I_Ld_FTk.d = 32'hA0 + {30'b0, s_addr[1:0]};
        end
        if (late_inj) begin
            I_Ld_FTk.v = 1'b1;
            I_Ld_FTk.d = 32'h0000DEAD;
            late_inj   = 1'b0;
        end
        I_BTk = '0;
        if (bp_left > 0) begin
            I_BTk.n = 1'b1;
            bp_left--;
        end
        I_FTk = '0;
        if (st_src.size() > 0) begin
            I_FTk.v = 1'b1;
            I_FTk.d = st_src[0];
        end
        I_St_BTk = '0;
        if (O_St_Req && O_St_Addr == nack_addr && nack_left > 0) begin
            I_St_BTk.n = 1'b1;
            nack_left--;
        end
    endtask

    task automatic run_cmd(input logic st, input logic [15:0] base, input logic [15:0] len,
                           input logic [15:0] stride);
        I_Cmd_V = 1'b1; I_Cmd_St = st; I_Cmd_Base = base; I_Cmd_Len = len; I_Cmd_Stride = stride;
        tick();
        I_Cmd_V = 1'b0;
        chk("cmd_accepted", 64'(acc_cyc >= 0), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int t = 0; t < 200 && done_cnt == 0; t++) tick();
        chk({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
        tick();
        tick();
        chk({tag, "_done_one_cycle"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic check_ld(input string tag);
        chk({tag, "_nreq"}, 64'(ld_addr_log.size()), 64'(exp_addr_q.size()));
        for (int j = 0; j < exp_addr_q.size() && j < ld_addr_log.size(); j++) begin
            chk($sformatf("%s_addr%0d", tag, j), 64'(ld_addr_log[j]), 64'(exp_addr_q[j]));
            chk($sformatf("%s_reqcyc%0d", tag, j), 64'(ld_cyc_log[j]), 64'(ld_cyc_log[0] + j));
        end
        chk({tag, "_npop"}, 64'(pop_d_log.size()), 64'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < pop_d_log.size(); j++) begin
            chk($sformatf("%s_d%0d", tag, j), 64'(pop_d_log[j]), 64'(exp_q[j]));
            chk($sformatf("%s_i%0d", tag, j), 64'(pop_i_log[j]), 64'(j));
            chk($sformatf("%s_a%0d", tag, j), 64'(pop_a_log[j]), 64'(j == 0));
            chk($sformatf("%s_r%0d", tag, j), 64'(pop_r_log[j]), 64'(j == exp_q.size() - 1));
        end
        chk({tag, "_done_after_last_pop"}, 64'(done_cyc), 64'(last_pop_cyc + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"},    64'(O_Cmd_Rdy), 64'd0);
        chk({tag, "_done"},   64'(O_Done),    64'd0);
        chk({tag, "_ldreq"},  64'(O_Ld_Req),  64'd0);
        chk({tag, "_ldaddr"}, 64'(O_Ld_Addr), 64'd0);
        chk({tag, "_ftk"},    64'(O_FTk),     64'd0);
        chk({tag, "_ldbtk"},  64'(O_Ld_BTk),  64'd0);
        chk({tag, "_btk"},    64'(O_BTk),     64'h2);
        chk({tag, "_streq"},  64'(O_St_Req),  64'd0);
        chk({tag, "_staddr"}, 64'(O_St_Addr), 64'd0);
        chk({tag, "_stftk"},  64'(O_St_FTk),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cyc = 0; both_req = 0;
        I_Cmd_V = 0; I_Cmd_St = 0; I_Cmd_Base = '0; I_Cmd_Len = '0; I_Cmd_Stride = '0;
        I_Ld_FTk = '0; I_BTk = '0; I_FTk = '0; I_St_BTk = '0;
        clear_logs();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;
        #1;
        chk("por_rdy_after_release", 64'(O_Cmd_Rdy), 64'd1);

        // Plain load, base 0x190 stride 1 len 4
        clear_logs();
        exp_addr_q = '{16'h0190, 16'h0191, 16'h0192, 16'h0193};
        exp_q      = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_cmd(1'b0, 16'h0190, 16'd4, 16'd1);
        wait_done("ld");
        check_ld("ld");

        // Same load, array stalls 6 cycles after word 0
        clear_logs();
        bp_after_first = 1'b1;
        exp_addr_q = '{16'h0190, 16'h0191, 16'h0192, 16'h0193};
        exp_q      = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_cmd(1'b0, 16'h0190, 16'd4, 16'd1);
        wait_done("ldstall");
        check_ld("ldstall");
        chk("ldstall_max_outstanding_le4", 64'(max_out <= 4), 64'd1);

        // Store, base 0x290 stride 2, data 5,6,7, nack 2 cycles on second word
        clear_logs();
        st_src = '{32'd5, 32'd6, 32'd7};
        nack_addr = 16'h0292;
        nack_left = 2;
        run_cmd(1'b1, 16'h0290, 16'd3, 16'd2);
        wait_done("st");
        exp_addr_q = '{16'h0290, 16'h0292, 16'h0294};
        exp_q      = '{32'd5, 32'd6, 32'd7};
        chk("st_nwrites", 64'(st_addr_log.size()), 64'd3);
        for (int j = 0; j < 3 && j < st_addr_log.size(); j++) begin
            chk($sformatf("st_addr%0d", j), 64'(st_addr_log[j]), 64'(exp_addr_q[j]));
            chk($sformatf("st_data%0d", j), 64'(st_d_log[j]), 64'(exp_q[j]));
        end
        chk("st_btk_n_during_nack", 64'(nack_bp), 64'd2);
        chk("st_no_ld_req", 64'(issued), 64'd0);
        chk("st_btk_n_idle", 64'(O_BTk.n), 64'd1);

        // Zero-length load
        clear_logs();
        run_cmd(1'b0, 16'h0190, 16'd0, 16'd1);
        wait_done("len0");
        chk("len0_done_cycle", 64'(done_cyc), 64'(acc_cyc + 1));
        chk("len0_no_req", 64'(issued), 64'd0);

        // Address wrap
        clear_logs();
        exp_addr_q = '{16'hFFFE, 16'hFFFF, 16'h0000};
        exp_q      = '{32'hA2, 32'hA3, 32'hA0};
        run_cmd(1'b0, 16'hFFFE, 16'd3, 16'd1);
        wait_done("wrap");
        check_ld("wrap");

        // Reset one cycle after the second request; memory answers during and after reset
        clear_logs();
        run_cmd(1'b0, 16'h0190, 16'd4, 16'd1);
        for (int t = 0; t < 20 && issued < 2; t++) tick();
        chk("rst_two_reqs", 64'(issued), 64'd2);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        late_inj = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_rdy_after_release", 64'(O_Cmd_Rdy), 64'd1);
        issued = 0; popped = 0; done_cnt = 0;
        repeat (4) tick();
        chk("rst_late_not_forwarded", 64'(popped), 64'd0);
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        chk("rst_no_req", 64'(issued), 64'd0);

        clear_logs();
        exp_addr_q = '{16'h0190, 16'h0191, 16'h0192, 16'h0193};
        exp_q      = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_cmd(1'b0, 16'h0190, 16'd4, 16'd1);
        wait_done("rst_fresh");
        check_ld("rst_fresh");

        chk("never_both_req", 64'(both_req), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
